// File: rtl/tls_pkg.sv
// Shared types and constants for the traffic phase scheduler: the phase
// enum, the bit positions of the lights vector, the light pattern for each
// phase, and small helpers for phase order and BCD conversion.
package tls_pkg;

  typedef enum logic [2:0] {
    AR_TO_X  = 3'd0,
    X_GREEN  = 3'd1,
    X_YELLOW = 3'd2,
    AR_TO_Y  = 3'd3,
    Y_GREEN  = 3'd4,
    Y_YELLOW = 3'd5,
    FLASH    = 3'd6
  } state_t;

  // lights = {Ry, Yy, Gy, Rx, Yx, Gx}
  localparam int LIGHT_GX = 0;
  localparam int LIGHT_YX = 1;
  localparam int LIGHT_RX = 2;
  localparam int LIGHT_GY = 3;
  localparam int LIGHT_YY = 4;
  localparam int LIGHT_RY = 5;

  localparam logic [5:0] LIGHTS_ALLRED   = 6'b100_100;
  localparam logic [5:0] LIGHTS_X_GREEN  = 6'b100_001;
  localparam logic [5:0] LIGHTS_X_YELLOW = 6'b100_010;
  localparam logic [5:0] LIGHTS_Y_GREEN  = 6'b001_100;
  localparam logic [5:0] LIGHTS_Y_YELLOW = 6'b010_100;
  localparam logic [5:0] LIGHTS_FLASH_ON = 6'b010_010;
  localparam logic [5:0] LIGHTS_DARK     = 6'b000_000;

  function automatic logic is_allred(state_t s);
    return (s == AR_TO_X) || (s == AR_TO_Y);
  endfunction

  function automatic logic is_green(state_t s);
    return (s == X_GREEN) || (s == Y_GREEN);
  endfunction

  // Normal rotation; FLASH always falls back to the X-side clearance.
  function automatic state_t next_phase(state_t s);
    state_t n;
    case (s)
      AR_TO_X:  n = X_GREEN;
      X_GREEN:  n = X_YELLOW;
      X_YELLOW: n = AR_TO_Y;
      AR_TO_Y:  n = Y_GREEN;
      Y_GREEN:  n = Y_YELLOW;
      default:  n = AR_TO_X;
    endcase
    return n;
  endfunction

  function automatic logic [5:0] phase_lights(state_t s, logic flash_on);
    logic [5:0] l;
    case (s)
      X_GREEN:  l = LIGHTS_X_GREEN;
      X_YELLOW: l = LIGHTS_X_YELLOW;
      Y_GREEN:  l = LIGHTS_Y_GREEN;
      Y_YELLOW: l = LIGHTS_Y_YELLOW;
      FLASH:    l = flash_on ? LIGHTS_FLASH_ON : LIGHTS_DARK;
      default:  l = LIGHTS_ALLRED;
    endcase
    return l;
  endfunction

  // 0..99 binary to {tens, units} BCD.
  function automatic logic [7:0] bin_to_bcd(logic [6:0] bin);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(bin / 7'd10);
    units = 4'(bin % 7'd10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Tick/request inputs and light/display outputs of the phase scheduler.
// master = the side driving tick and requests, slave = the scheduler.
interface traffic_phase_scheduler_if;
  import tls_pkg::*;

  logic       tick;
  logic       flash_req;
  logic       ped_req;
  logic       ped_ack;
  logic [5:0] lights;
  logic [7:0] count_bcd;
  state_t     phase;
  logic       sec_pulse;

  modport master (
    output tick, flash_req, ped_req,
    input  ped_ack, lights, count_bcd, phase, sec_pulse
  );

  modport slave (
    input  tick, flash_req, ped_req,
    output ped_ack, lights, count_bcd, phase, sec_pulse
  );
endinterface

// File: rtl/tls_bin2bcd.sv
// Combinational 7-bit binary to 2-digit BCD; the parent registers the result.
module tls_bin2bcd
  import tls_pkg::*;
(
  input  logic [6:0] bin,
  output logic [7:0] bcd
);

  // Pure conversion, valid for 0..99.
  always_comb begin
    bcd = bin_to_bcd(bin);
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase sequencer with per-phase seconds countdown
// (BCD) and night-flash mode. Optional pedestrian green-shortening is
// compiled in when TLS_PED_REQ_EN is defined.
module traffic_phase_scheduler
  import tls_pkg::*;
#(
  parameter int unsigned TX_GREEN      = 30,
  parameter int unsigned TY_GREEN      = 15,
  parameter int unsigned T_YELLOW      = 3,
  parameter int unsigned T_ALLRED      = 1,
  parameter int unsigned T_PED         = 5,
  parameter int unsigned TICKS_PER_SEC = 10
) (
  input logic                       clk,
  input logic                       rst,
  traffic_phase_scheduler_if.slave  bus
);

  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);
  localparam logic [6:0] SEC_ALLRED = 7'(T_ALLRED);
  localparam logic [6:0] SEC_PED    = 7'(T_PED);

  function automatic logic [6:0] phase_duration(state_t s);
    logic [6:0] d;
    case (s)
      X_GREEN:            d = 7'(TX_GREEN);
      Y_GREEN:            d = 7'(TY_GREEN);
      X_YELLOW, Y_YELLOW: d = 7'(T_YELLOW);
      default:            d = SEC_ALLRED;
    endcase
    return d;
  endfunction

  state_t           state_reg, state_next;
  logic [6:0]       sec_left_reg, sec_left_next;
  logic [SUB_W-1:0] sub_cnt_reg, sub_cnt_next;
  logic             flash_on_reg, flash_on_next;
  logic [5:0]       lights_reg, lights_next;
  logic [7:0]       count_bcd_reg, count_bcd_next;
  logic [7:0]       sec_left_bcd;
  logic             sec_pulse_reg;
  logic             sec_event;
  logic             ped_pending;

  tls_bin2bcd u_bin2bcd (
    .bin (sec_left_next),
    .bcd (sec_left_bcd)
  );

  // Sub-second prescaler, seconds countdown and phase transitions.
  always_comb begin
    state_next    = state_reg;
    sec_left_next = sec_left_reg;
    sub_cnt_next  = sub_cnt_reg;
    flash_on_next = flash_on_reg;
    sec_event     = 1'b0;

    if (bus.tick) begin
      if (sub_cnt_reg == SUB_LAST) begin
        sub_cnt_next = '0;
        sec_event    = 1'b1;
      end else begin
        sub_cnt_next = sub_cnt_reg + 1'b1;
      end
    end

    if (sec_event) begin
      if (state_reg == FLASH) begin
        if (!bus.flash_req) begin
          state_next    = AR_TO_X;
          sec_left_next = SEC_ALLRED;
        end else begin
          flash_on_next = ~flash_on_reg;
        end
      end else if (sec_left_reg > 7'd1) begin
        // A pending pedestrian request trims a long green down to T_PED.
        if (ped_pending && is_green(state_reg) && (sec_left_reg > SEC_PED)) begin
          sec_left_next = SEC_PED;
        end else begin
          sec_left_next = sec_left_reg - 7'd1;
        end
      end else if (is_allred(state_reg) && bus.flash_req) begin
        // Flash is only entered from a clearance, never by cutting a green.
        state_next    = FLASH;
        sec_left_next = '0;
        flash_on_next = 1'b1;
      end else begin
        state_next    = next_phase(state_reg);
        sec_left_next = phase_duration(next_phase(state_reg));
      end
    end

    lights_next = phase_lights(state_next, flash_on_next);
  end

  // Display value follows the new countdown; blank (00) while flashing.
  always_comb begin
    count_bcd_next = (state_next == FLASH) ? 8'h00 : sec_left_bcd;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= AR_TO_X;
      sec_left_reg  <= SEC_ALLRED;
      sub_cnt_reg   <= '0;
      flash_on_reg  <= 1'b0;
      lights_reg    <= LIGHTS_ALLRED;
      count_bcd_reg <= bin_to_bcd(SEC_ALLRED);
      sec_pulse_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sec_left_reg  <= sec_left_next;
      sub_cnt_reg   <= sub_cnt_next;
      flash_on_reg  <= flash_on_next;
      lights_reg    <= lights_next;
      count_bcd_reg <= count_bcd_next;
      sec_pulse_reg <= sec_event;
    end
  end

  assign bus.lights    = lights_reg;
  assign bus.count_bcd = count_bcd_reg;
  assign bus.phase     = state_reg;
  assign bus.sec_pulse = sec_pulse_reg;

`ifdef TLS_PED_REQ_EN
  logic ped_latch_reg;
  logic ped_ack_reg;
  logic enter_allred;

  // A request arriving on the serving edge is merged into that service.
  assign ped_pending  = ped_latch_reg | bus.ped_req;
  assign enter_allred = sec_event && (state_next != state_reg) && is_allred(state_next);

  // Request latch, served (cleared and acked) on the next all-red entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_latch_reg <= 1'b0;
      ped_ack_reg   <= 1'b0;
    end else begin
      ped_latch_reg <= ped_pending & ~enter_allred;
      ped_ack_reg   <= ped_pending & enter_allred;
    end
  end

  assign bus.ped_ack = ped_ack_reg;
`else
  logic ped_req_unused;

  assign ped_pending    = 1'b0;
  assign ped_req_unused = bus.ped_req;
  assign bus.ped_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler. Stimulus pushes the expected
// post-second view {phase, lights, count_bcd, ped_ack} per seconds pulse;
// the monitor compares on every sec_pulse cycle.
module tb_traffic_phase_scheduler;
  import tls_pkg::*;

  localparam logic [5:0] L_AR  = 6'b100100;
  localparam logic [5:0] L_XG  = 6'b100001;
  localparam logic [5:0] L_XY  = 6'b100010;
  localparam logic [5:0] L_YG  = 6'b001100;
  localparam logic [5:0] L_YY  = 6'b010100;
  localparam logic [5:0] L_FL  = 6'b010010;
  localparam logic [5:0] L_OFF = 6'b000000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler #(
    .TX_GREEN      (5),
    .TY_GREEN      (3),
    .T_YELLOW      (2),
    .T_ALLRED      (1),
    .T_PED         (2),
    .TICKS_PER_SEC (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    state_t     ph;
    logic [5:0] lights;
    logic [7:0] bcd;
    logic       ack;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_w;
  int    checks    = 0;
  int    errors    = 0;
  int    txn       = 0;
  int    ack_cnt   = 0;
  int    pulse_cnt = 0;
  string cur_test  = "init";

  task automatic push(input state_t ph, input logic [5:0] l, input logic [7:0] b, input logic a);
    exp_t e;
    e.ph = ph; e.lights = l; e.bcd = b; e.ack = a;
    exp_q.push_back(e);
  endtask

  // Descending countdown n_hi..n_lo (single digit values) within one phase.
  task automatic push_down(input state_t ph, input logic [5:0] l, input int n_hi, input int n_lo);
    for (int n = n_hi; n >= n_lo; n--) push(ph, l, {4'd0, 4'(n)}, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s got %0h want %0h", cur_test, name, got, want);
    end
  endtask

  // Monitor: one comparison per seconds pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ped_ack) ack_cnt++;
      if (bus.sec_pulse) begin
        pulse_cnt++;
        checks++;
        txn++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected sec_pulse got ph=%0d lights=%b bcd=%h ack=%b want none",
                   cur_test, bus.phase, bus.lights, bus.count_bcd, bus.ped_ack);
        end else begin
          mon_w = exp_q.pop_front();
          if (bus.phase !== mon_w.ph || bus.lights !== mon_w.lights ||
              bus.count_bcd !== mon_w.bcd || bus.ped_ack !== mon_w.ack) begin
            errors++;
            $display("FAIL %s txn%0d got ph=%0d lights=%b bcd=%h ack=%b want ph=%0d lights=%b bcd=%h ack=%b",
                     cur_test, txn, bus.phase, bus.lights, bus.count_bcd, bus.ped_ack,
                     mon_w.ph, mon_w.lights, mon_w.bcd, mon_w.ack);
          end else begin
            $display("txn %0d %s ph=%0d lights=%b bcd=%h ack=%b ok",
                     txn, cur_test, bus.phase, bus.lights, bus.count_bcd, bus.ped_ack);
          end
        end
      end
    end
  end

  task automatic do_reset();
    bus.flash_req = 1'b0;
    bus.ped_req   = 1'b0;
    bus.tick      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_phase",  32'(bus.phase),     32'(AR_TO_X));
    chk("rst_lights", 32'(bus.lights),    32'(L_AR));
    chk("rst_bcd",    32'(bus.count_bcd), 32'h01);
    chk("rst_pulse",  32'(bus.sec_pulse), 32'd0);
    chk("rst_ack",    32'(bus.ped_ack),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_sec(input int n);
    int c;
    for (int k = 0; k < n; k++) begin
      c = 0;
      do begin
        @(posedge clk); #1;
        c++;
      end while (!bus.sec_pulse && c < 50);
      if (!bus.sec_pulse) begin
        checks++;
        errors++;
        $display("FAIL %s sec_pulse timeout got 0 want 1", cur_test);
      end
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_base;
    int pulse_base;
    bus.tick      = 1'b0;
    bus.flash_req = 1'b0;
    bus.ped_req   = 1'b0;

    // 1: one full rotation
    cur_test = "cycle";
    do_reset();
    push_down(X_GREEN, L_XG, 5, 1);
    push_down(X_YELLOW, L_XY, 2, 1);
    push(AR_TO_Y, L_AR, 8'h01, 1'b0);
    push_down(Y_GREEN, L_YG, 3, 1);
    push_down(Y_YELLOW, L_YY, 2, 1);
    push(AR_TO_X, L_AR, 8'h01, 1'b0);
    drain();

    // 2: asynchronous reset in the middle of Y_GREEN
    cur_test = "async_rst";
    do_reset();
    push_down(X_GREEN, L_XG, 5, 1);
    push_down(X_YELLOW, L_XY, 2, 1);
    push(AR_TO_Y, L_AR, 8'h01, 1'b0);
    push(Y_GREEN, L_YG, 8'h03, 1'b0);
    wait_sec(9);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_phase",  32'(bus.phase),     32'(AR_TO_X));
    chk("mid_lights", 32'(bus.lights),    32'(L_AR));
    chk("mid_bcd",    32'(bus.count_bcd), 32'h01);
    chk("mid_ack",    32'(bus.ped_ack),   32'd0);
    chk("mid_queue",  32'(exp_q.size()),  32'd0);

    // 3: night flash entered from AR_TO_Y, left through AR_TO_X
    cur_test = "flash";
    do_reset();
    push(X_GREEN, L_XG, 8'h05, 1'b0);
    wait_sec(1);
    bus.flash_req = 1'b1;
    push_down(X_GREEN, L_XG, 4, 1);
    push_down(X_YELLOW, L_XY, 2, 1);
    push(AR_TO_Y, L_AR, 8'h01, 1'b0);
    push(FLASH, L_FL, 8'h00, 1'b0);
    push(FLASH, L_OFF, 8'h00, 1'b0);
    push(FLASH, L_FL, 8'h00, 1'b0);
    wait_sec(10);
    bus.flash_req = 1'b0;
    push(AR_TO_X, L_AR, 8'h01, 1'b0);
    push(X_GREEN, L_XG, 8'h05, 1'b0);
    drain();

`ifdef TLS_PED_REQ_EN
    // 4: pedestrian cut of a long X green
    cur_test = "ped_cut";
    do_reset();
    ack_base = ack_cnt;
    push(X_GREEN, L_XG, 8'h05, 1'b0);
    wait_sec(1);
    bus.ped_req = 1'b1;
    @(posedge clk); #1;
    bus.ped_req = 1'b0;
    push_down(X_GREEN, L_XG, 2, 1);
    push_down(X_YELLOW, L_XY, 2, 1);
    push(AR_TO_Y, L_AR, 8'h01, 1'b1);
    push(Y_GREEN, L_YG, 8'h03, 1'b0);
    drain();
    chk("ack_count", 32'(ack_cnt - ack_base), 32'd1);

    // 5: late requests in Y green, merged, no timing change
    cur_test = "ped_late";
    do_reset();
    ack_base = ack_cnt;
    push_down(X_GREEN, L_XG, 5, 1);
    push_down(X_YELLOW, L_XY, 2, 1);
    push(AR_TO_Y, L_AR, 8'h01, 1'b0);
    push_down(Y_GREEN, L_YG, 3, 1);
    push_down(Y_YELLOW, L_YY, 2, 1);
    push(AR_TO_X, L_AR, 8'h01, 1'b1);
    push(X_GREEN, L_XG, 8'h05, 1'b0);
    wait_sec(10);
    bus.ped_req = 1'b1;
    @(posedge clk); #1;
    bus.ped_req = 1'b0;
    wait_sec(1);
    bus.ped_req = 1'b1;
    @(posedge clk); #1;
    bus.ped_req = 1'b0;
    drain();
    chk("ack_count", 32'(ack_cnt - ack_base), 32'd1);
`else
    // 4/5: pedestrian input has no effect when the feature is absent
    cur_test = "ped_off";
    do_reset();
    ack_base = ack_cnt;
    push(X_GREEN, L_XG, 8'h05, 1'b0);
    wait_sec(1);
    bus.ped_req = 1'b1;
    @(posedge clk); #1;
    bus.ped_req = 1'b0;
    push_down(X_GREEN, L_XG, 4, 1);
    push_down(X_YELLOW, L_XY, 2, 1);
    push(AR_TO_Y, L_AR, 8'h01, 1'b0);
    drain();
    chk("ack_count", 32'(ack_cnt - ack_base), 32'd0);
`endif

    // 6: tick held low freezes everything
    cur_test = "tick_hold";
    do_reset();
    push(X_GREEN, L_XG, 8'h05, 1'b0);
    wait_sec(1);
    bus.tick = 1'b0;
    @(negedge clk); #1;
    pulse_base = pulse_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("hold_phase",  32'(bus.phase),     32'(X_GREEN));
    chk("hold_lights", 32'(bus.lights),    32'(L_XG));
    chk("hold_bcd",    32'(bus.count_bcd), 32'h05);
    chk("hold_pulse",  32'(bus.sec_pulse), 32'd0);
    chk("hold_pulses", 32'(pulse_cnt - pulse_base), 32'd0);
    bus.tick = 1'b1;
    push_down(X_GREEN, L_XG, 4, 3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
